// File: rtl/alu_program_sequencer_if.sv
// Host, program-ROM and ALU signals of the ALU program sequencer.
// The sequencer connects through the slave modport; the host/environment side
// (ROM, ALU and the register preload/readback port) uses the master modport.
interface alu_program_sequencer_if #(
  parameter int BITS    = 8,
  parameter int OP      = 4,
  parameter int SIZE    = 4,
  parameter int INSTR_W = 16
);
  logic               start;
  logic               busy;
  logic               done;
  logic               err;
  logic               wr_en;
  logic [1:0]         wr_idx;
  logic [BITS-1:0]    wr_data;
  logic [1:0]         rd_idx;
  logic [BITS-1:0]    rd_data;
  logic               rom_en;
  logic [SIZE-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               alu_reset;
  logic [OP-1:0]      alu_op;
  logic [BITS-1:0]    alu_a;
  logic [BITS-1:0]    alu_b;
  logic [BITS-1:0]    alu_out;

  modport master (
    output start, wr_en, wr_idx, wr_data, rd_idx, rom_data, alu_out,
    input  busy, done, err, rd_data, rom_en, rom_addr, alu_reset, alu_op, alu_a, alu_b
  );

  modport slave (
    input  start, wr_en, wr_idx, wr_data, rd_idx, rom_data, alu_out,
    output busy, done, err, rd_data, rom_en, rom_addr, alu_reset, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_program_sequencer.sv
// Microsequencer that runs a short program from a registered-output ROM
// against an external ALU, using a four-entry internal register file.
// Each instruction takes three cycles: FETCH (ROM read), WAIT (ROM data lands
// in the instruction register) and EXEC (ALU driven, result written back).
// Instruction layout (top bits first): op, dst, src1, src2, then reserved bits.
// Only op/dst/src1/src2 are kept in the instruction register; the reserved bits
// are never looked at.
module alu_program_sequencer #(
  parameter int BITS    = 8,
  parameter int OP      = 4,
  parameter int SIZE    = 4,
  parameter int INSTR_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  alu_program_sequencer_if.slave bus
);

  localparam int IR_W = OP + 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SIZE-1:0]        pc_q, pc_d;
  logic [IR_W-1:0]        ir_q, ir_d;
  logic                   err_q, err_d;
  logic [3:0][BITS-1:0]   regs_q, regs_d;

  logic [OP-1:0]          op;
  logic [1:0]             dst;
  logic [1:0]             src1;
  logic [1:0]             src2;
  logic                   is_halt;
  logic                   div_by_zero;
  logic                   busy;
  logic                   unused_rsvd;

  // Decoded fields of the latched instruction.
  assign op          = ir_q[IR_W-1 -: OP];
  assign dst         = ir_q[5:4];
  assign src1        = ir_q[3:2];
  assign src2        = ir_q[1:0];
  assign is_halt     = (op == {OP{1'b1}});
  assign div_by_zero = ((op == OP'(3)) || (op == OP'(4))) && (regs_q[src2] == '0);
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EXEC);
  assign unused_rsvd = ^bus.rom_data[INSTR_W-IR_W-1:0];

  // State, program counter, instruction register, error flag and register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  // Next-state logic: host writes while idle, program sequencing while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    regs_d  = regs_q;

    if (!busy && bus.wr_en) begin
      regs_d[bus.wr_idx] = bus.wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        ir_d    = bus.rom_data[INSTR_W-1 -: IR_W];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_halt) begin
          state_d = S_DONE;
        end else if (div_by_zero) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          regs_d[dst] = bus.alu_out;
          if (pc_q == {SIZE{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: status, ROM request, and ALU drive that is zero outside EXEC.
  always_comb begin
    bus.busy      = busy;
    bus.done      = (state_q == S_DONE);
    bus.err       = err_q;
    bus.rd_data   = regs_q[bus.rd_idx];
    bus.rom_en    = (state_q == S_FETCH);
    bus.rom_addr  = pc_q;
    bus.alu_reset = 1'b0;
    bus.alu_op    = '0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    if (state_q == S_EXEC) begin
      bus.alu_reset = 1'b1;
      bus.alu_op    = op;
      bus.alu_a     = regs_q[src1];
      bus.alu_b     = regs_q[src2];
    end
  end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Testbench for alu_program_sequencer: ROM and ALU models, a table of
// programs with expected register/err/latency results pushed to a scoreboard
// at start and compared when done pulses, plus a mid-run reset sequence.
module tb_alu_program_sequencer;

  localparam int BITS    = 8;
  localparam int OP      = 4;
  localparam int SIZE    = 4;
  localparam int INSTR_W = 16;
  localparam int NVEC    = 6;
  localparam int TIMEOUT = 200;

  typedef struct {
    logic [3:0][7:0]   pre;
    logic [15:0][15:0] prog;
    logic [3:0][7:0]   exp_regs;
    int                exp_cycle;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic [3:0][7:0] regs;
    int              cycle;
    logic            err;
    int              id;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NVEC];
  exp_t sb[$];
  logic [15:0] rom [16];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  alu_program_sequencer_if #(.BITS(BITS), .OP(OP), .SIZE(SIZE), .INSTR_W(INSTR_W)) bus ();

  alu_program_sequencer #(.BITS(BITS), .OP(OP), .SIZE(SIZE), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Registered-output program ROM.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  // ALU model: cleared while alu_reset is low, opcodes 8..15 add.
  always_comb begin
    bus.alu_out = '0;
    if (bus.alu_reset) begin
      case (bus.alu_op)
        4'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
        4'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
        4'd2:    bus.alu_out = bus.alu_a * bus.alu_b;
        4'd3:    bus.alu_out = (bus.alu_b != 0) ? bus.alu_a / bus.alu_b : '0;
        4'd4:    bus.alu_out = (bus.alu_b != 0) ? bus.alu_a % bus.alu_b : '0;
        4'd5:    bus.alu_out = bus.alu_a & bus.alu_b;
        4'd6:    bus.alu_out = bus.alu_a | bus.alu_b;
        4'd7:    bus.alu_out = bus.alu_a ^ bus.alu_b;
        default: bus.alu_out = bus.alu_a + bus.alu_b;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic writeReg(input logic [1:0] idx, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Pop the oldest expectation and compare it with what the DUT produced.
  task automatic checkOutput(input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("v%0d_done_cycle", e.id), cyc, e.cycle);
    check($sformatf("v%0d_err", e.id), int'(bus.err), int'(e.err));
    for (int r = 0; r < 4; r++) begin
      bus.rd_idx = 2'(r);
      #1;
      check($sformatf("v%0d_r%0d", e.id, r), int'(bus.rd_data), int'(e.regs[r]));
    end
    @(negedge clk);
    check($sformatf("v%0d_done_one_cycle", e.id), int'(bus.done), 0);
    check($sformatf("v%0d_err_sticky", e.id), int'(bus.err), int'(e.err));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.busy || bus.rom_en) begin
        check($sformatf("v%0d_stays_idle", e.id), 1, 0);
        break;
      end
    end
  endtask

  // Load a program, preload registers (last write coincides with start), run it.
  // With intrude set, a register write and a second start are driven mid-run.
  task automatic applyStimulus(input int v, input bit intrude);
    exp_t e;
    int   cyc;
    bit   got;
    for (int a = 0; a < 16; a++) rom[a] = vecs[v].prog[a];
    for (int r = 0; r < 3; r++) writeReg(2'(r), vecs[v].pre[r]);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = 2'd3;
    bus.wr_data = vecs[v].pre[3];
    bus.start   = 1'b1;
    e.regs  = vecs[v].exp_regs;
    e.cycle = vecs[v].exp_cycle;
    e.err   = vecs[v].exp_err;
    e.id    = v;
    sb.push_back(e);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (cyc == 1) begin
        check($sformatf("v%0d_err_cleared", v), int'(bus.err), 0);
        check($sformatf("v%0d_busy", v), int'(bus.busy), 1);
      end
      if (intrude && cyc == 2) begin
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 2'd1;
        bus.wr_data = 8'd99;
        bus.start   = 1'b1;
      end
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (!got) begin
      check($sformatf("v%0d_done_timeout", v), cyc, vecs[v].exp_cycle);
      void'(sb.pop_front());
    end else begin
      checkOutput(cyc);
    end
  endtask

  int  cyc;
  bit  saw_done;
  bit  saw_rom;

  initial begin
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_data = '0;
    bus.rd_idx  = '0;
    for (int a = 0; a < 16; a++) rom[a] = 16'hF000;

    // Program table: preload, program, expected registers, done cycle, err.
    for (int v = 0; v < NVEC; v++) begin
      vecs[v].pre      = '0;
      vecs[v].prog     = {16{16'hF000}};
      vecs[v].exp_regs = '0;
      vecs[v].exp_err  = 1'b0;
    end
    // ADD R2=R0+R1, MUL R3=R2*R1, HALT
    vecs[0].pre      = {8'd0, 8'd0, 8'd3, 8'd5};
    vecs[0].prog[0]  = 16'h0900;
    vecs[0].prog[1]  = 16'h2E40;
    vecs[0].exp_regs = {8'd24, 8'd8, 8'd3, 8'd5};
    vecs[0].exp_cycle = 10;
    // ADD R0=R0+R1 with 8-bit wrap, HALT
    vecs[1].pre      = {8'd0, 8'd0, 8'd100, 8'd200};
    vecs[1].prog[0]  = 16'h0040;
    vecs[1].exp_regs = {8'd0, 8'd0, 8'd100, 8'd44};
    vecs[1].exp_cycle = 7;
    // DIV R2=R0/R1 with R1=0 stops immediately, ADD R3=R0+R0 never runs
    vecs[2].pre      = {8'd0, 8'd0, 8'd0, 8'd9};
    vecs[2].prog[0]  = 16'h3840;
    vecs[2].prog[1]  = 16'h0C00;
    vecs[2].exp_regs = {8'd0, 8'd0, 8'd0, 8'd9};
    vecs[2].exp_cycle = 4;
    vecs[2].exp_err  = 1'b1;
    // op 8 behaves as ADD, dst equals both sources: R1=R1+R1
    vecs[3].pre      = {8'd0, 8'd0, 8'd2, 8'd7};
    vecs[3].prog[0]  = 16'h8540;
    vecs[3].exp_regs = {8'd0, 8'd0, 8'd4, 8'd7};
    vecs[3].exp_cycle = 7;
    // Modulo R3=R0%R1 with R1=0: R3 keeps its preload
    vecs[4].pre      = {8'd77, 8'd0, 8'd0, 8'd5};
    vecs[4].prog[0]  = 16'h4C40;
    vecs[4].exp_regs = {8'd77, 8'd0, 8'd0, 8'd5};
    vecs[4].exp_cycle = 4;
    vecs[4].exp_err  = 1'b1;
    // Sixteen ADD R0=R0+R1, no HALT: ends at the last address without wrapping
    vecs[5].pre      = {8'd0, 8'd0, 8'd1, 8'd0};
    vecs[5].prog     = {16{16'h0040}};
    vecs[5].exp_regs = {8'd0, 8'd0, 8'd1, 8'd16};
    vecs[5].exp_cycle = 49;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_rom_en", int'(bus.rom_en), 0);
    check("rst_alu_reset", int'(bus.alu_reset), 0);
    check("rst_alu_op", int'(bus.alu_op), 0);
    reset = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      bus.rd_idx = 2'(r);
      #1;
      check($sformatf("rst_r%0d", r), int'(bus.rd_data), 0);
    end
    @(negedge clk);

    for (int v = 0; v < NVEC; v++) applyStimulus(v, 1'b0);

    // Mid-run reset in the WAIT state of instruction 2.
    for (int a = 0; a < 16; a++) rom[a] = vecs[0].prog[a];
    writeReg(2'd0, 8'd5);
    writeReg(2'd1, 8'd3);
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
    end
    bus.rd_idx = 2'd2;
    #1;
    check("mid_r2_live", int'(bus.rd_data), 8);
    check("mid_busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_rom_en", int'(bus.rom_en), 0);
    check("abort_alu_reset", int'(bus.alu_reset), 0);
    for (int r = 0; r < 4; r++) begin
      bus.rd_idx = 2'(r);
      #1;
      check($sformatf("abort_r%0d", r), int'(bus.rd_data), 0);
    end
    saw_done = 1'b0;
    saw_rom  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      if (bus.done) saw_done = 1'b1;
      if (bus.rom_en) saw_rom = 1'b1;
    end
    check("abort_no_done", int'(saw_done), 0);
    check("abort_no_rom", int'(saw_rom), 0);

    // Write and start while busy are both ignored.
    applyStimulus(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
